// File: rtl/lab5_led_sequencer.sv
// Autonomous LED pattern engine: Avalon-MM config slave plus a write-only master
// that periodically pushes rotate/bounce/count/blink patterns into the LED PIO.
module lab5_led_sequencer #(
  parameter int unsigned                PERIOD_W       = 24,
  parameter logic [PERIOD_W-1:0]        DEFAULT_PERIOD = 24'd5000000,
  parameter int unsigned                LED_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cfg_address,
  input  logic        cfg_chipselect,
  input  logic        cfg_write_n,
  input  logic [31:0] cfg_writedata,
  output logic [31:0] cfg_readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  output logic        running
);

  typedef enum logic [2:0] {StIdle, StLoad, StWrite, StWait, StClear} state_e;

  state_e               state_q, state_d;
  logic                 en_q;
  logic [1:0]           mode_q;
  logic [PERIOD_W-1:0]  period_q, cnt_q, cnt_d, period_last;
  logic [7:0]           seed_q;
  logic [LED_W-1:0]     pattern_q, pattern_d, next_pattern;
  logic                 dir_q, dir_d, next_dir;  // 0 = shifting left, 1 = shifting right
  logic                 cfg_wr, ctrl_wr, period_wr, seed_wr, en_rise, tick;
  logic                 unused_wdata;

  assign cfg_wr       = cfg_chipselect && !cfg_write_n;
  assign ctrl_wr      = cfg_wr && (cfg_address == 2'd0);
  assign period_wr    = cfg_wr && (cfg_address == 2'd1);
  assign seed_wr      = cfg_wr && (cfg_address == 2'd2);
  assign en_rise      = ctrl_wr && cfg_writedata[0] && !en_q;
  assign unused_wdata = ^cfg_writedata[31:PERIOD_W];

  // A programmed period of 0 behaves as 1
  assign period_last = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
  assign tick        = (state_q == StWait) && (cnt_q == period_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q     <= 1'b0;
      mode_q   <= 2'd0;
      period_q <= DEFAULT_PERIOD;
      seed_q   <= 8'h01;
    end else begin
      if (ctrl_wr) begin
        en_q   <= cfg_writedata[0];
        mode_q <= cfg_writedata[2:1];
      end
      if (period_wr) period_q <= cfg_writedata[PERIOD_W-1:0];
      if (seed_wr)   seed_q   <= cfg_writedata[7:0];
    end
  end

  always_comb begin
    next_pattern = pattern_q;
    next_dir     = dir_q;
    case (mode_q)
      2'd0: next_pattern = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
      2'd1: begin
        if (!dir_q && pattern_q[LED_W-1]) begin
          next_dir     = 1'b1;
          next_pattern = pattern_q >> 1;
        end else if (dir_q && pattern_q[0]) begin
          next_dir     = 1'b0;
          next_pattern = pattern_q << 1;
        end else if (dir_q) begin
          next_pattern = pattern_q >> 1;
        end else begin
          next_pattern = pattern_q << 1;
        end
      end
      2'd2:    next_pattern = pattern_q + LED_W'(1);
      default: next_pattern = (pattern_q == '0) ? LED_W'(seed_q) : '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    case (state_q)
      StIdle: if (en_rise) state_d = StLoad;
      StLoad: begin
        if (!en_q) begin
          state_d = StClear;
        end else begin
          pattern_d = LED_W'(seed_q);
          dir_d     = 1'b0;
          cnt_d     = '0;
          state_d   = StWrite;
        end
      end
      StWrite: state_d = en_q ? StWait : StClear;
      StWait: begin
        if (!en_q) begin
          state_d = StClear;
        end else if (tick) begin
          pattern_d = next_pattern;
          dir_d     = next_dir;
          cnt_d     = '0;
          state_d   = StWrite;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      StClear: begin
        pattern_d = '0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A new period restarts the count immediately
    if (period_wr) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pattern_q <= '0;
      dir_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
    end
  end

  // Bus outputs decode straight from state so reset silences them at once
  always_comb begin
    pio_address    = 2'd0;
    pio_chipselect = (state_q == StWrite) || (state_q == StClear);
    pio_write_n    = !pio_chipselect;
    pio_writedata  = (state_q == StWrite) ? 32'(pattern_q) : 32'd0;
    running        = (state_q == StLoad) || (state_q == StWrite) || (state_q == StWait);
  end

  always_comb begin
    case (cfg_address)
      2'd0:    cfg_readdata = {29'b0, mode_q, en_q};
      2'd1:    cfg_readdata = 32'(period_q);
      2'd2:    cfg_readdata = {24'b0, seed_q};
      default: cfg_readdata = {16'b0, pattern_q[7:0], 7'b0, running};
    endcase
  end

endmodule

// File: tb/tb_lab5_led_sequencer.sv
// Bench for lab5_led_sequencer: captures every PIO write and compares the sequence
// and timing against an arithmetic model of the pattern rules.
module tb_lab5_led_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cfg_address;
  logic        cfg_chipselect;
  logic        cfg_write_n;
  logic [31:0] cfg_writedata;
  logic [31:0] cfg_readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic        running;

  typedef struct {
    int cyc;
    int data;
    int addr;
    bit run;
  } wr_t;

  wr_t cap_q[$];
  int  exp_q[$];
  int  cyc     = 0;
  int  n_tests = 0;
  int  n_fail  = 0;

  lab5_led_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_address    (cfg_address),
    .cfg_chipselect (cfg_chipselect),
    .cfg_write_n    (cfg_write_n),
    .cfg_writedata  (cfg_writedata),
    .cfg_readdata   (cfg_readdata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .running        (running)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && pio_chipselect && !pio_write_n)
      cap_q.push_back('{cyc, int'(pio_writedata), int'(pio_address), running});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d, output int w);
    @(negedge clk);
    cfg_chipselect = 1'b1;
    cfg_write_n    = 1'b0;
    cfg_address    = a;
    cfg_writedata  = d;
    @(posedge clk);
    #1;
    w              = cyc;
    cfg_chipselect = 1'b0;
    cfg_write_n    = 1'b1;
  endtask

  task automatic cfg_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    cfg_address = a;
    #1;
    d = cfg_readdata;
  endtask

  // Expected pattern sequence, derived from the mode rules with plain integers
  function automatic void build_expected(input int mode, input int seed, input int n);
    int p;
    int left;
    p    = seed;
    left = 1;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      case (mode)
        0: p = ((p * 2) % 256) + (p / 128);
        1: begin
          if (left == 1) begin
            if (p >= 128) begin left = 0; p = p / 2; end
            else p = (p * 2) % 256;
          end else begin
            if (p % 2 == 1) begin left = 1; p = (p * 2) % 256; end
            else p = p / 2;
          end
        end
        2: p = (p + 1) % 256;
        default: p = (p == 0) ? seed : 0;
      endcase
    end
  endfunction

  task automatic run_seq(input string tag, input int mode, input int seed, input int period,
                         input int n);
    int          peff, w, last, cnt;
    logic [31:0] rd;
    peff = (period == 0) ? 1 : period;
    cfg_wr(2'd1, period, w);
    cfg_wr(2'd2, seed, w);
    cap_q.delete();
    cfg_wr(2'd0, (mode << 1) | 1, w);
    build_expected(mode, seed, n);
    last = w + 1 + (n - 1) * (peff + 1);
    repeat (last + 1 - w) @(posedge clk);
    @(negedge clk);
    #1;
    check({tag, ":count"}, cap_q.size(), n);
    cnt = (cap_q.size() < n) ? cap_q.size() : n;
    for (int i = 0; i < cnt; i++) begin
      check($sformatf("%s:data%0d", tag, i), cap_q[i].data, exp_q[i]);
      check($sformatf("%s:cyc%0d", tag, i), cap_q[i].cyc, w + 1 + i * (peff + 1));
      check($sformatf("%s:addr%0d", tag, i), cap_q[i].addr, 0);
    end
    check({tag, ":running"}, running, 1);
    cfg_rd(2'd3, rd);
    check({tag, ":status_pat"}, rd[15:8], (cap_q.size() > 0) ? cap_q[cap_q.size()-1].data : -1);
    check({tag, ":status_run"}, rd[0], 1);
    // Disable: exactly one write of 0 with running already low, then idle
    cfg_wr(2'd0, 0, w);
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    cnt = 0;
    foreach (cap_q[i]) if (!cap_q[i].run) cnt++;
    check({tag, ":clear_writes"}, cnt, 1);
    check({tag, ":clear_data"}, (cap_q.size() > 0) ? cap_q[cap_q.size()-1].data : -1, 0);
    check({tag, ":clear_run"}, (cap_q.size() > 0) ? cap_q[cap_q.size()-1].run : 1'b1, 0);
    check({tag, ":idle_running"}, running, 0);
  endtask

  initial begin
    int          w;
    logic [31:0] rd;
    reset          = 1'b1;
    cfg_address    = 2'd0;
    cfg_chipselect = 1'b0;
    cfg_write_n    = 1'b1;
    cfg_writedata  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    cfg_rd(2'd1, rd); check("rst:period", rd, 32'd5000000);
    cfg_rd(2'd0, rd); check("rst:ctrl", rd, 32'd0);
    cfg_rd(2'd2, rd); check("rst:seed", rd, 32'd1);
    cfg_rd(2'd3, rd); check("rst:status", rd, 32'd0);
    check("rst:cs", pio_chipselect, 0);
    check("rst:wn", pio_write_n, 1);
    check("rst:running", running, 0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("rst:no_writes", cap_q.size(), 0);

    // EN=0 while idle and STATUS writes cause nothing
    cfg_wr(2'd0, 32'd0, w);
    cfg_wr(2'd3, 32'hFFFF_FFFF, w);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("idle:no_writes", cap_q.size(), 0);
    cfg_rd(2'd3, rd); check("idle:status", rd, 32'd0);

    // Directed mode runs
    run_seq("rotate", 0, 'h81, 3, 4);
    run_seq("bounce", 1, 'h40, 0, 10);
    run_seq("count", 2, 'hFE, 1, 5);
    run_seq("blink", 3, 'hA5, 2, 6);

    // Asynchronous reset while waiting
    cfg_wr(2'd1, 32'd10, w);
    cfg_wr(2'd2, 32'h3C, w);
    cfg_wr(2'd0, 32'd1, w);
    repeat (6) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst:cs", pio_chipselect, 0);
    check("arst:wn", pio_write_n, 1);
    check("arst:wdata", pio_writedata, 0);
    check("arst:running", running, 0);
    @(negedge clk);
    reset = 1'b0;
    cap_q.delete();
    cfg_rd(2'd1, rd); check("arst:period", rd, 32'd5000000);
    cfg_rd(2'd0, rd); check("arst:ctrl", rd, 32'd0);
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("arst:no_writes", cap_q.size(), 0);

    // Randomized runs
    for (int k = 0; k < 6; k++) begin
      run_seq($sformatf("rand%0d", k), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 4)), 6);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
